// File: rtl/am_bip_lane_error_monitor.sv
// Multi-lane BIP8 error monitor: per-lane two-stage compare/accumulate with saturating
// counters, snapshot shadow bank, sticky overflow and a registered lane read port.

module am_bip_lane #(
  parameter int NB_BIP     = 8,
  parameter int NB_COUNTER = 16,
  parameter int NB_INC     = $clog2(NB_BIP + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  mode,
  input  logic                  valid,
  input  logic                  match,
  input  logic [NB_BIP-1:0]     rx,
  input  logic [NB_BIP-1:0]     calc,
  input  logic                  reset_count,
  input  logic                  snapshot,
  output logic                  inc_nz,
  output logic [NB_COUNTER-1:0] shadow,
  output logic                  overflow
);
  localparam int NB_SUM = NB_COUNTER + 1;

  logic [NB_BIP-1:0]     diff;
  logic [NB_INC-1:0]     pop;
  logic [NB_INC-1:0]     sample;
  logic [NB_INC-1:0]     inc_q;
  logic [NB_COUNTER-1:0] live;
  logic [NB_SUM-1:0]     sum;

  always_comb begin
    diff = rx ^ calc;
    pop  = '0;
    for (int i = 0; i < NB_BIP; i++) pop = pop + NB_INC'(diff[i]);
    sample = '0;
    if (enable && valid && match) sample = mode ? pop : NB_INC'(|diff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inc_q <= '0;
    else     inc_q <= sample;
  end

  assign inc_nz = |inc_q;
  // extra MSB catches the carry that triggers saturation
  assign sum    = {1'b0, live} + NB_SUM'(inc_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live     <= '0;
      shadow   <= '0;
      overflow <= 1'b0;
    end else if (reset_count) begin
      live     <= '0;
      shadow   <= '0;
      overflow <= 1'b0;
    end else if (snapshot) begin
      // the increment arriving this cycle seeds the fresh interval
      shadow <= live;
      live   <= NB_COUNTER'(inc_q);
    end else if (sum[NB_COUNTER]) begin
      live     <= '1;
      overflow <= 1'b1;
    end else begin
      live <= sum[NB_COUNTER-1:0];
    end
  end
endmodule

module am_bip_lane_error_monitor #(
  parameter int N_LANES     = 20,
  parameter int NB_BIP      = 8,
  parameter int NB_COUNTER  = 16,
  parameter int NB_LANE_SEL = 5
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic                        i_mode,
  input  logic [N_LANES-1:0]          i_valid,
  input  logic [N_LANES-1:0]          i_match,
  input  logic [N_LANES*NB_BIP-1:0]   i_recived_bip,
  input  logic [N_LANES*NB_BIP-1:0]   i_calculated_bip,
  input  logic                        i_reset_count,
  input  logic                        i_snapshot,
  input  logic [NB_LANE_SEL-1:0]      i_rd_lane,
  output logic [NB_COUNTER-1:0]       o_rd_count,
  output logic                        o_rd_overflow,
  output logic [N_LANES-1:0]          o_overflow,
  output logic                        o_error_any
);
  localparam logic [NB_LANE_SEL-1:0] LAST_LANE = NB_LANE_SEL'(N_LANES - 1);

  logic [N_LANES-1:0]                 inc_nz;
  logic [N_LANES-1:0][NB_COUNTER-1:0] shadow;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    am_bip_lane #(
      .NB_BIP     (NB_BIP),
      .NB_COUNTER (NB_COUNTER)
    ) u_lane (
      .clk         (i_clock),
      .rst         (i_reset),
      .enable      (i_enable),
      .mode        (i_mode),
      .valid       (i_valid[k]),
      .match       (i_match[k]),
      .rx          (i_recived_bip[k*NB_BIP +: NB_BIP]),
      .calc        (i_calculated_bip[k*NB_BIP +: NB_BIP]),
      .reset_count (i_reset_count),
      .snapshot    (i_snapshot),
      .inc_nz      (inc_nz[k]),
      .shadow      (shadow[k]),
      .overflow    (o_overflow[k])
    );
  end

  // inc_nz comes straight from stage-1 flops, so this is already one cycle late
  assign o_error_any = |inc_nz;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_rd_count    <= '0;
      o_rd_overflow <= 1'b0;
    end else if (i_rd_lane <= LAST_LANE) begin
      o_rd_count    <= shadow[i_rd_lane];
      o_rd_overflow <= o_overflow[i_rd_lane];
    end else begin
      o_rd_count    <= '0;
      o_rd_overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_am_bip_lane_error_monitor.sv
// Directed bench for am_bip_lane_error_monitor with a 4-bit counter so saturation is
// reachable in a few markers; lane counts are observed through snapshot + read port.

module tb_am_bip_lane_error_monitor;
  localparam int N  = 20;
  localparam int NB = 8;
  localparam int NC = 4;
  localparam int NS = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b1;
  logic            mode = 1'b0;
  logic [N-1:0]    valid = '0;
  logic [N-1:0]    match = '0;
  logic [N*NB-1:0] rxb = '0;
  logic [N*NB-1:0] calcb = '0;
  logic            reset_count = 1'b0;
  logic            snapshot = 1'b0;
  logic [NS-1:0]   rd_lane = '0;
  logic [NC-1:0]   rd_count;
  logic            rd_overflow;
  logic [N-1:0]    overflow;
  logic            error_any;

  int errors = 0;
  int checks = 0;

  am_bip_lane_error_monitor #(
    .N_LANES(N), .NB_BIP(NB), .NB_COUNTER(NC), .NB_LANE_SEL(NS)
  ) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_enable         (enable),
    .i_mode           (mode),
    .i_valid          (valid),
    .i_match          (match),
    .i_recived_bip    (rxb),
    .i_calculated_bip (calcb),
    .i_reset_count    (reset_count),
    .i_snapshot       (snapshot),
    .i_rd_lane        (rd_lane),
    .o_rd_count       (rd_count),
    .o_rd_overflow    (rd_overflow),
    .o_overflow       (overflow),
    .o_error_any      (error_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int lane, input logic [7:0] rx, input logic [7:0] calc);
    valid[lane] = 1'b1;
    match[lane] = 1'b1;
    rxb[lane*NB +: NB]   = rx;
    calcb[lane*NB +: NB] = calc;
  endtask

  task automatic idle;
    valid = '0;
    match = '0;
    rxb   = '0;
    calcb = '0;
  endtask

  task automatic marker(input int lane, input logic [7:0] rx, input logic [7:0] calc);
    drive(lane, rx, calc);
    tick;
    idle;
  endtask

  task automatic snap;
    snapshot = 1'b1;
    tick;
    snapshot = 1'b0;
  endtask

  task automatic rd(input int lane, input int exp_cnt, input logic exp_ov, input string tag);
    rd_lane = NS'(lane);
    tick;
    chk({tag, "_cnt"}, 32'(rd_count), 32'(exp_cnt));
    chk({tag, "_ov"}, 32'(rd_overflow), 32'(exp_ov));
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_rd_count", 32'(rd_count), 0);
    chk("rst_rd_ov", 32'(rd_overflow), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_error_any", 32'(error_any), 0);
    rst = 1'b0;
    tick;

    // 1: mode 0 counts one per errored marker, mode 1 counts popcount
    drive(3, 8'hA5, 8'hA4);
    tick;
    chk("t1_err_m0", 32'(error_any), 1);
    idle;
    tick;
    chk("t1_err_m0_off", 32'(error_any), 0);
    mode = 1'b1;
    drive(3, 8'h0F, 8'h00);
    tick;
    chk("t1_err_m1", 32'(error_any), 1);
    idle;
    tick;
    chk("t1_err_m1_off", 32'(error_any), 0);
    snap;
    rd(3, 5, 1'b0, "t1_lane3");
    rd(4, 0, 1'b0, "t1_lane4");
    rd(2, 0, 1'b0, "t1_lane2");

    // 2: gated markers do not count
    match[3] = 1'b1;
    rxb[3*NB +: NB] = 8'hFF;
    tick;
    chk("t2_err_novalid", 32'(error_any), 0);
    valid[3] = 1'b1;
    enable = 1'b0;
    tick;
    chk("t2_err_noen", 32'(error_any), 0);
    idle;
    enable = 1'b1;
    tick;
    snap;
    rd(3, 0, 1'b0, "t2_lane3");

    // 3: saturation and sticky overflow on lane 5
    marker(5, 8'hFF, 8'h00);
    marker(5, 8'h3F, 8'h00);
    tick;
    chk("t3_ovf_at14", 32'(overflow), 0);
    marker(5, 8'hFF, 8'h00);
    tick;
    chk("t3_ovf_set", 32'(overflow), 32'h20);
    marker(5, 8'hFF, 8'h00);
    tick;
    chk("t3_ovf_hold", 32'(overflow), 32'h20);
    snap;
    rd(5, 15, 1'b1, "t3_sat");
    snap;
    rd(5, 0, 1'b1, "t3_live_cleared");
    reset_count = 1'b1;
    tick;
    reset_count = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 0);
    rd(5, 0, 1'b0, "t3_after_clr");

    // 4: snapshot coincident with stage-2 increment
    marker(0, 8'hFF, 8'h00);
    marker(0, 8'h03, 8'h00);
    drive(0, 8'h07, 8'h00);
    tick;
    idle;
    snapshot = 1'b1;
    tick;
    snapshot = 1'b0;
    rd(0, 10, 1'b0, "t4_shadow");
    snap;
    rd(0, 3, 1'b0, "t4_kept_inc");
    marker(0, 8'h01, 8'h00);
    tick;
    reset_count = 1'b1;
    snapshot = 1'b1;
    tick;
    reset_count = 1'b0;
    snapshot = 1'b0;
    rd(0, 0, 1'b0, "t4_clr_shadow");
    snap;
    rd(0, 0, 1'b0, "t4_clr_live");

    // 5: read port latency and out-of-range lane
    marker(7, 8'h03, 8'h00);
    tick;
    snap;
    rd(25, 0, 1'b0, "t5_lane25");
    rd_lane = 5'd7;
    #1;
    chk("t5_latency", 32'(rd_count), 0);
    tick;
    chk("t5_lane7", 32'(rd_count), 2);
    rd(7, 2, 1'b0, "t5_reread");

    // 6: asynchronous reset mid-accumulation
    marker(9, 8'hFF, 8'h00);
    marker(9, 8'hFF, 8'h00);
    tick;
    chk("t6_ovf9", 32'(overflow), 32'h200);
    marker(2, 8'h0F, 8'h00);
    tick;
    drive(2, 8'hFF, 8'h00);
    tick;
    chk("t6_err_pre", 32'(error_any), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_err", 32'(error_any), 0);
    chk("t6_rst_ovf", 32'(overflow), 0);
    chk("t6_rst_cnt", 32'(rd_count), 0);
    idle;
    #3;
    rst = 1'b0;
    tick;
    marker(2, 8'h01, 8'h00);
    tick;
    snap;
    rd(2, 1, 1'b0, "t6_post_lane2");
    rd(7, 0, 1'b0, "t6_post_lane7");
    rd(9, 0, 1'b0, "t6_post_lane9");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
